// File: rtl/sample_assembler_pkg.sv
// Shared types and constants for the sample assembler slice.
// Optional partial-sample timeout is enabled by defining SAMPLE_ASM_TIMEOUT_EN.
package sample_asm_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_NUM_UNITS      = 2;
  localparam int DEF_UNIT_W         = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Byte counter width: enough for up to 4 bytes per sample (32-bit samples).
  localparam int BCNT_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  function automatic int bytes_per_sample(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sample_assembler_if.sv
// Byte-input / sample-output / error bundle of the sample assembler.
// master: the side feeding bytes and consuming samples; slave: the assembler.
interface sample_asm_if
  import sample_asm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int UNIT_W     = DEF_UNIT_W
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic [UNIT_W-1:0]     unit_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_sample;
  logic [UNIT_W-1:0]     out_unit;
  logic                  err_frame;
  logic                  err_overrun;
  logic                  err_clr;

  modport master (
    output byte_in, byte_valid, unit_sel, out_ready, err_clr,
    input  out_valid, out_sample, out_unit, err_frame, err_overrun
  );

  modport slave (
    input  byte_in, byte_valid, unit_sel, out_ready, err_clr,
    output out_valid, out_sample, out_unit, err_frame, err_overrun
  );
endinterface

// File: rtl/sample_assembler_strobe_sync.sv
// Three-flop synchroniser for the asynchronous byte strobe plus a
// rising-edge detector. The detector stays disarmed after reset until the
// synchronised strobe has been seen low, so a level held across reset
// release never produces a byte.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_stb
);
  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       r_armed;
  logic [1:0] r_live;

  // Synchroniser chain, post-reset fill tracker and edge-detector arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_armed <= 1'b0;
      r_live  <= 2'b00;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      // r_live[1] means r_s2 now holds a genuinely sampled input value.
      r_live <= {r_live[0], 1'b1};
      if (r_live[1] && !r_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_stb = r_s2 & ~r_s3 & r_armed;

endmodule

// File: rtl/sample_assembler.sv
// Assembles an MSB-first byte stream into DATA_WIDTH-bit samples tagged
// with a detector unit, presented through a one-entry valid/ready register.
// Define SAMPLE_ASM_TIMEOUT_EN to abandon stalled partial samples after
// TIMEOUT_CYCLES strobe-free cycles.
module sample_assembler
  import sample_asm_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_UNITS      = DEF_NUM_UNITS,
  parameter int UNIT_W         = DEF_UNIT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  sample_asm_if.slave bus
);
  localparam int                BPS        = bytes_per_sample(DATA_WIDTH);
  localparam logic [BCNT_W-1:0] LAST_BCNT  = BCNT_W'(BPS - 1);
  localparam logic [UNIT_W:0]   UNIT_LIMIT = (UNIT_W + 1)'(NUM_UNITS);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 32 ||
      NUM_UNITS < 1 || NUM_UNITS > 4 || NUM_UNITS > (1 << UNIT_W) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sample_assembler: illegal parameter combination");
  end

  asm_state_t            r_state;
  logic [BCNT_W-1:0]     r_bcnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [UNIT_W-1:0]     r_cur_unit;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_sample;
  logic [UNIT_W-1:0]     r_out_unit;
  logic                  r_err_frame;
  logic                  r_err_overrun;

  logic                  w_stb;
  logic                  w_unit_ok;
  logic                  w_same_unit;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_complete;
  logic                  w_timeout;

  strobe_sync u_strobe_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(bus.byte_valid),
    .o_stb  (w_stb)
  );

  assign w_unit_ok   = {1'b0, bus.unit_sel} < UNIT_LIMIT;
  assign w_same_unit = (bus.unit_sel == r_cur_unit);
  // Partial data with the incoming byte appended; for 8-bit samples the
  // shift empties the register so this is just the byte itself.
  assign w_shifted   = (r_shift << 8) | DATA_WIDTH'(bus.byte_in);

  // A sample completes when the strobed byte is the last one of its sample.
  always_comb begin
    w_complete = 1'b0;
    if (w_stb && w_unit_ok) begin
      if (r_state == IDLE) begin
        w_complete = (BPS == 1);
      end else begin
        w_complete = w_same_unit && (r_bcnt == LAST_BCNT);
      end
    end
  end

`ifdef SAMPLE_ASM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_idle_cnt;

  assign w_timeout = (r_state == COLLECT) && !w_stb &&
                     (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts strobe-free cycles while a partial sample is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != COLLECT || w_stb || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Assembly FSM together with the output register and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bcnt        <= '0;
      r_shift       <= '0;
      r_cur_unit    <= '0;
      r_out_valid   <= 1'b0;
      r_out_sample  <= '0;
      r_out_unit    <= '0;
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_frame <= 1'b0;

      // Output slot: a completion refills it whenever it is empty or being
      // drained on this edge; otherwise the new sample is lost.
      if (w_complete && (!r_out_valid || bus.out_ready)) begin
        r_out_valid  <= 1'b1;
        r_out_sample <= w_shifted;
        r_out_unit   <= bus.unit_sel;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Overrun setting takes priority over a simultaneous clear.
      if (w_complete && r_out_valid && !bus.out_ready) begin
        r_err_overrun <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_overrun <= 1'b0;
      end

      if (w_stb) begin
        if (!w_unit_ok) begin
          r_err_frame <= 1'b1;
          r_state     <= IDLE;
          r_bcnt      <= '0;
          r_shift     <= '0;
        end else if (r_state == IDLE || !w_same_unit) begin
          // New MSB; a unit change mid-sample abandons the partial data.
          r_err_frame <= (r_state == COLLECT);
          r_shift     <= DATA_WIDTH'(bus.byte_in);
          r_cur_unit  <= bus.unit_sel;
          if (BPS == 1) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
          end else begin
            r_state <= COLLECT;
            r_bcnt  <= BCNT_W'(1);
          end
        end else begin
          r_shift <= w_shifted;
          if (r_bcnt == LAST_BCNT) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
          end else begin
            r_bcnt <= r_bcnt + BCNT_W'(1);
          end
        end
      end else if (w_timeout) begin
        r_err_frame <= 1'b1;
        r_state     <= IDLE;
        r_bcnt      <= '0;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_sample  = r_out_sample;
  assign bus.out_unit    = r_out_unit;
  assign bus.err_frame   = r_err_frame;
  assign bus.err_overrun = r_err_overrun;

endmodule

// File: tb/tb_sample_assembler.sv
// Self-checking bench for sample_assembler: directed steps from the test
// plan followed by randomized bytes, checked against a byte-queue model.
module tb_sample_assembler;
  localparam int DW  = 16;
  localparam int NU  = 2;
  localparam int UW  = 2;
  localparam int TO  = 20;
  localparam int BPS = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_asm_if #(.DATA_WIDTH(DW), .UNIT_W(UW)) bus ();

  sample_assembler #(
    .DATA_WIDTH(DW), .NUM_UNITS(NU), .UNIT_W(UW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]    pq[$];
  int            punit = 0;
  bit            slot_v = 0;
  logic [DW-1:0] slot_s = '0;
  logic [UW-1:0] slot_u = '0;
  bit            m_over = 0;
  bit            m_ready = 0;
  int            m_frames = 0;
  int            o_frames = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   got_q[$];
  bit            to_en;
  int            rise_idx, fall_idx, frame_idx;

  function automatic logic [31:0] pack(input logic [UW-1:0] u, input logic [DW-1:0] s);
    return {{(32 - UW - DW){1'b0}}, u, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_complete(input logic [DW-1:0] s, input int u);
    if (m_ready) exp_q.push_back(pack(UW'(u), s));
    else if (!slot_v) begin
      slot_v = 1; slot_s = s; slot_u = UW'(u);
    end else m_over = 1;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int u);
    logic [31:0] s;
    if (u >= NU) begin
      m_frames++; pq.delete(); return;
    end
    if (pq.size() > 0 && u != punit) begin
      m_frames++; pq.delete();
    end
    pq.push_back(b);
    punit = u;
    if (pq.size() == BPS) begin
      s = 0;
      foreach (pq[i]) s = (s << 8) | 32'(pq[i]);
      pq.delete();
      model_complete(s[DW-1:0], u);
    end
  endfunction

  // Observe transfers and error pulses half a cycle away from the edge.
  always begin
    @(negedge clk); #2;
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(pack(bus.out_unit, bus.out_sample));
    if (!rst && bus.err_frame) o_frames++;
  end

  task automatic send_byte(input logic [7:0] b, input int u, input int hi, input int lo);
    bit prev_v;
    @(negedge clk);
    bus.byte_in = b; bus.unit_sel = UW'(u); bus.byte_valid = 1'b1;
    rise_idx = -1; fall_idx = -1; frame_idx = -1;
    prev_v = bus.out_valid;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk); #1;
      if (i == hi) bus.byte_valid = 1'b0;
      if (bus.out_valid && !prev_v && rise_idx < 0) rise_idx = i;
      if (!bus.out_valid && prev_v && fall_idx < 0) fall_idx = i;
      if (bus.err_frame && frame_idx < 0) frame_idx = i;
      prev_v = bus.out_valid;
    end
    model_byte(b, u);
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b, input int u);
    send_byte(a, u, 1, 3);
    send_byte(b, u, 1, 3);
  endtask

  task automatic set_ready(input bit r);
    @(negedge clk);
    bus.out_ready = r; m_ready = r;
    if (r && slot_v) begin
      exp_q.push_back(pack(slot_u, slot_s)); slot_v = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_err();
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    m_over = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (to_en && pq.size() > 0 && n >= TO) begin
      m_frames++; pq.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    pq.delete(); slot_v = 0; m_over = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    @(negedge clk); #3;
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(slot_v));
    if (slot_v) begin
      chk({tag, ".sample"}, 32'(bus.out_sample), 32'(slot_s));
      chk({tag, ".unit"}, 32'(bus.out_unit), 32'(slot_u));
    end
    chk({tag, ".overrun"}, 32'(bus.err_overrun), 32'(m_over));
    chk({tag, ".frames"}, o_frames, m_frames);
    chk({tag, ".ntransfers"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".transfer"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SAMPLE_ASM_TIMEOUT_EN
    to_en = 1;
`else
    to_en = 0;
`endif
    rst = 1'b1;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.unit_sel = '0;
    bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.valid", 32'(bus.out_valid), 0);
    chk("reset.sample", 32'(bus.out_sample), 0);
    chk("reset.unit", 32'(bus.out_unit), 0);
    chk("reset.frame", 32'(bus.err_frame), 0);
    chk("reset.overrun", 32'(bus.err_overrun), 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic: 0x12,0x34 on unit 1 with the consumer always ready
    set_ready(1);
    send2(8'h12, 8'h34, 1);
    chk("basic.rise_cycle", rise_idx, 3);
    chk("basic.fall_cycle", fall_idx, 4);
    checkpoint("basic");

    // Sign passthrough
    set_ready(0);
    send2(8'hFF, 8'hF0, 0);
    checkpoint("sign_fff0");
    set_ready(1);
    checkpoint("sign_fff0_drain");
    set_ready(0);
    send2(8'h80, 8'h00, 0);
    checkpoint("sign_8000");
    set_ready(1);
    checkpoint("sign_8000_drain");

    // Backpressure and overrun
    set_ready(0);
    send2(8'h00, 8'h01, 1);
    send2(8'h00, 8'h02, 1);
    checkpoint("bp_hold");
    clear_err();
    checkpoint("bp_clr");
    set_ready(1);
    checkpoint("bp_drain");

    // Framing: unit change mid-sample, then out-of-range unit
    send_byte(8'hAA, 0, 1, 3);
    send_byte(8'hBB, 1, 1, 3);
    chk("frame.change_cycle", frame_idx, 3);
    send_byte(8'hCC, 1, 1, 3);
    checkpoint("frame_change");
    send_byte(8'h44, 0, 1, 3);
    send_byte(8'h3C, 3, 1, 3);
    chk("frame.range_cycle", frame_idx, 3);
    send2(8'h55, 8'h66, 0);
    checkpoint("frame_range");

    // Reset mid-sample, then a strobe held high across reset release
    send_byte(8'h55, 0, 1, 3);
    do_reset(3);
    @(negedge clk); rst = 1'b1;
    bus.byte_in = 8'h99; bus.unit_sel = '0; bus.byte_valid = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk); bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    pq.delete(); slot_v = 0; m_over = 0;
    send2(8'h66, 8'h77, 0);
    checkpoint("reset_mid");

    // Stalled half-sample
    send_byte(8'h11, 0, 1, 3);
    idle(25);
    send2(8'h22, 8'h33, 0);
    checkpoint("timeout");

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int u;
      if ($urandom_range(0, 3) == 0) set_ready(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) clear_err();
      if ($urandom_range(0, 9) == 0) u = 3;
      else if ($urandom_range(0, 4) == 0) u = $urandom_range(0, NU - 1);
      else u = punit;
      send_byte(8'($urandom), u, $urandom_range(1, 3), $urandom_range(2, 4));
      idle($urandom_range(0, 4));
      if (n % 10 == 9) checkpoint("random");
    end
    set_ready(1);
    checkpoint("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
